// File: rtl/xsumrecv_pkg.sv
// Shared definitions for the inter-Xilinx local-sum receiver: comma symbol,
// link state encoding, word-class encoding and the word classifier.
package xsumrecv_pkg;

  localparam logic [15:0] CH_COMMA = 16'h00BC;
  localparam logic [1:0]  K_COMMA  = 2'b01;
  localparam int          NLINK    = 3;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_LOCK = 2'd1,
    ST_UP   = 2'd2
  } link_state_t;

  typedef enum logic [1:0] {
    WC_COMMA = 2'd0,
    WC_DATA  = 2'd1,
    WC_ERROR = 2'd2
  } word_class_t;

  // Zero never appears as data: the transmitter replaces a zero sum with a comma.
  function automatic word_class_t classify(input logic [15:0] data, input logic [1:0] isk);
    word_class_t c;
    if ((isk == K_COMMA) && (data == CH_COMMA)) begin
      c = WC_COMMA;
    end else if ((isk == 2'b00) && (data != 16'h0000)) begin
      c = WC_DATA;
    end else begin
      c = WC_ERROR;
    end
    return c;
  endfunction

endpackage

// File: rtl/xsumrecv_xlinkrx.sv
// One receive link: word classifier, HUNT/LOCK/UP lock tracker, leaky-bucket
// error filter and saturating error counter.
module xlinkrx
  import xsumrecv_pkg::*;
#(
  parameter int LOCKCNT = 16,
  parameter int ERRMAX  = 4,
  parameter int LEAK    = 64,
  parameter int ECBITS  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [15:0]       i_data,
  input  logic [1:0]        i_isk,
  input  logic              i_cnt_clr,
  output word_class_t       o_class,
  output logic              o_up,
  output logic              o_count_err,
  output logic [ECBITS-1:0] o_errcnt
);

  localparam int CW = $clog2(LOCKCNT + 1);
  localparam int BW = $clog2(ERRMAX + 1);
  localparam int LW = $clog2(LEAK + 1);

  link_state_t       r_state;
  link_state_t       w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [CW-1:0]     w_cnt_inc;
  logic [BW-1:0]     r_bucket;
  logic [BW-1:0]     w_bucket_nxt;
  logic [BW-1:0]     w_bucket_inc;
  logic [LW-1:0]     r_leak;
  logic [LW-1:0]     w_leak_nxt;
  logic [LW-1:0]     w_leak_inc;
  logic [ECBITS-1:0] r_ec;
  logic [ECBITS-1:0] w_ec_nxt;
  logic              w_count_err;
  word_class_t       w_class;

  assign w_class      = classify(i_data, i_isk);
  assign w_cnt_inc    = r_cnt + CW'(1);
  assign w_bucket_inc = r_bucket + BW'(1);
  assign w_leak_inc   = r_leak + LW'(1);

  // Lock tracking and leaky bucket; errors seen while hunting are not counted.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bucket_nxt = r_bucket;
    w_leak_nxt   = r_leak;
    w_count_err  = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_class == WC_COMMA) begin
          w_state_nxt = ST_LOCK;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_state_nxt = ST_HUNT;
        end
      end
      ST_LOCK: begin
        if (w_class == WC_ERROR) begin
          w_state_nxt = ST_HUNT;
          w_cnt_nxt   = {CW{1'b0}};
          w_count_err = 1'b1;
        end else if (w_cnt_inc == CW'(LOCKCNT)) begin
          w_state_nxt  = ST_UP;
          w_cnt_nxt    = {CW{1'b0}};
          w_bucket_nxt = {BW{1'b0}};
          w_leak_nxt   = {LW{1'b0}};
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_UP: begin
        if (w_class == WC_ERROR) begin
          w_count_err = 1'b1;
          w_leak_nxt  = {LW{1'b0}};
          if (w_bucket_inc == BW'(ERRMAX)) begin
            w_state_nxt  = ST_HUNT;
            w_bucket_nxt = {BW{1'b0}};
          end else begin
            w_bucket_nxt = w_bucket_inc;
          end
        end else if (w_leak_inc == LW'(LEAK)) begin
          w_leak_nxt   = {LW{1'b0}};
          w_bucket_nxt = (r_bucket == {BW{1'b0}}) ? {BW{1'b0}} : (r_bucket - BW'(1));
        end else begin
          w_leak_nxt = w_leak_inc;
        end
      end
      default: begin
        w_state_nxt  = ST_HUNT;
        w_cnt_nxt    = {CW{1'b0}};
        w_bucket_nxt = {BW{1'b0}};
        w_leak_nxt   = {LW{1'b0}};
      end
    endcase
  end

  // Clear wins over count, so a same-cycle error leaves the counter at one.
  always_comb begin
    if (i_cnt_clr) begin
      w_ec_nxt = w_count_err ? ECBITS'(1) : {ECBITS{1'b0}};
    end else if (w_count_err && (r_ec != {ECBITS{1'b1}})) begin
      w_ec_nxt = r_ec + ECBITS'(1);
    end else begin
      w_ec_nxt = r_ec;
    end
  end

  // Link state and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_HUNT;
      r_cnt    <= {CW{1'b0}};
      r_bucket <= {BW{1'b0}};
      r_leak   <= {LW{1'b0}};
      r_ec     <= {ECBITS{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bucket <= w_bucket_nxt;
      r_leak   <= w_leak_nxt;
      r_ec     <= w_ec_nxt;
    end
  end

  assign o_class     = w_class;
  assign o_up        = (r_state == ST_UP);
  assign o_count_err = w_count_err;
  assign o_errcnt    = r_ec;

endmodule

// File: rtl/xsumrecv.sv
// Receiver for the three inter-Xilinx local-sum links: per-link checking and
// lock tracking, then gating of untrusted words to comma (zero contribution).
module xsumrecv
  import xsumrecv_pkg::*;
#(
  parameter int LOCKCNT = 16,
  parameter int ERRMAX  = 4,
  parameter int LEAK    = 64,
  parameter int ECBITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [47:0]           rxdata,
  input  logic [5:0]            rxcharisk,
  input  logic [2:0]            linkmask,
  input  logic                  cnt_clr,
  output logic [47:0]           xdata,
  output logic [2:0]            xcomma,
  output logic [2:0]            linkup,
  output logic [3*ECBITS-1:0]   errcnt,
  output logic                  err
);

  word_class_t       w_class [NLINK];
  logic [NLINK-1:0]  w_up;
  logic [NLINK-1:0]  w_count_err;
  logic [47:0]       w_xdata_nxt;
  logic [2:0]        w_xcomma_nxt;
  logic [47:0]       r_xdata;
  logic [2:0]        r_xcomma;
  logic              r_err;

  for (genvar k = 0; k < NLINK; k++) begin : g_link
    xlinkrx #(
      .LOCKCNT (LOCKCNT),
      .ERRMAX  (ERRMAX),
      .LEAK    (LEAK),
      .ECBITS  (ECBITS)
    ) u_link (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_data      (rxdata[16*k +: 16]),
      .i_isk       (rxcharisk[2*k +: 2]),
      .i_cnt_clr   (cnt_clr),
      .o_class     (w_class[k]),
      .o_up        (w_up[k]),
      .o_count_err (w_count_err[k]),
      .o_errcnt    (errcnt[ECBITS*k +: ECBITS])
    );
  end

  // Gating uses the state before this edge: the word that completes lock is still a comma.
  always_comb begin
    w_xdata_nxt  = {NLINK{CH_COMMA}};
    w_xcomma_nxt = 3'b111;
    for (int k = 0; k < NLINK; k++) begin
      if (w_up[k] && !linkmask[k] && (w_class[k] == WC_DATA)) begin
        w_xdata_nxt[16*k +: 16] = rxdata[16*k +: 16];
        w_xcomma_nxt[k]         = 1'b0;
      end else begin
        w_xdata_nxt[16*k +: 16] = CH_COMMA;
        w_xcomma_nxt[k]         = 1'b1;
      end
    end
  end

  // Output registers toward the 64-channel sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xdata  <= {NLINK{CH_COMMA}};
      r_xcomma <= 3'b111;
      r_err    <= 1'b0;
    end else begin
      r_xdata  <= w_xdata_nxt;
      r_xcomma <= w_xcomma_nxt;
      r_err    <= |w_count_err;
    end
  end

  assign xdata  = r_xdata;
  assign xcomma = r_xcomma;
  assign linkup = w_up;
  assign err    = r_err;

endmodule

// File: tb/tb_xsumrecv.sv
// Self-checking bench for xsumrecv: directed scenarios plus random traffic,
// all compared against a behavioural per-link model.
module tb_xsumrecv;

  localparam int LOCKCNT = 16;
  localparam int ERRMAX  = 4;
  localparam int LEAK    = 64;
  localparam int ECB     = 10;
  localparam int EC_MAX  = (1 << ECB) - 1;

  logic              clk;
  logic              reset;
  logic [47:0]       rxdata;
  logic [5:0]        rxcharisk;
  logic [2:0]        linkmask;
  logic              cnt_clr;
  logic [47:0]       xdata;
  logic [2:0]        xcomma;
  logic [2:0]        linkup;
  logic [3*ECB-1:0]  errcnt;
  logic              err;

  xsumrecv #(
    .LOCKCNT (LOCKCNT),
    .ERRMAX  (ERRMAX),
    .LEAK    (LEAK),
    .ECBITS  (ECB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxdata    (rxdata),
    .rxcharisk (rxcharisk),
    .linkmask  (linkmask),
    .cnt_clr   (cnt_clr),
    .xdata     (xdata),
    .xcomma    (xcomma),
    .linkup    (linkup),
    .errcnt    (errcnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Stimulus for the next edge.
  logic [15:0] d_w [3];
  logic [1:0]  d_k [3];
  logic [2:0]  d_mask;
  logic        d_clr;
  logic        d_reset;

  // Model state: 0 = hunting, 1 = locking, 2 = up.
  int          m_st   [3];
  int          m_cnt  [3];
  int          m_bkt  [3];
  int          m_leak [3];
  int          m_ec   [3];
  logic [15:0] e_xd   [3];
  logic [2:0]  e_xc;
  logic        e_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0 = comma, 1 = data, 2 = error
  function automatic int word_cls(input logic [15:0] w, input logic [1:0] k);
    if (k == 2'b01 && w == 16'h00BC) return 0;
    if (k == 2'b00 && w != 16'h0000) return 1;
    return 2;
  endfunction

  task automatic model_edge();
    int  c;
    bit  counted;
    bit  pass;
    e_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (d_reset) begin
        m_st[k] = 0; m_cnt[k] = 0; m_bkt[k] = 0; m_leak[k] = 0; m_ec[k] = 0;
        e_xd[k] = 16'h00BC; e_xc[k] = 1'b1;
      end else begin
        c       = word_cls(d_w[k], d_k[k]);
        counted = 0;
        pass    = (m_st[k] == 2) && !d_mask[k] && (c == 1);
        e_xd[k] = pass ? d_w[k] : 16'h00BC;
        e_xc[k] = pass ? 1'b0 : 1'b1;
        if (m_st[k] == 0) begin
          if (c == 0) begin m_st[k] = 1; m_cnt[k] = 1; end
        end else if (m_st[k] == 1) begin
          if (c == 2) begin
            m_st[k] = 0; counted = 1;
          end else begin
            m_cnt[k]++;
            if (m_cnt[k] == LOCKCNT) begin m_st[k] = 2; m_bkt[k] = 0; m_leak[k] = 0; end
          end
        end else begin
          if (c == 2) begin
            counted = 1; m_leak[k] = 0; m_bkt[k]++;
            if (m_bkt[k] == ERRMAX) m_st[k] = 0;
          end else begin
            m_leak[k]++;
            if (m_leak[k] == LEAK) begin
              m_leak[k] = 0;
              if (m_bkt[k] > 0) m_bkt[k]--;
            end
          end
        end
        if (d_clr) m_ec[k] = 0;
        if (counted && m_ec[k] < EC_MAX) m_ec[k]++;
        if (counted) e_err = 1'b1;
      end
    end
  endtask

  // Apply one word per link, advance the model, compare after the edge.
  task automatic step();
    logic [3*ECB-1:0] exp_ec;
    logic [2:0]       exp_up;
    @(negedge clk);
    reset    = d_reset;
    rxdata   = {d_w[2], d_w[1], d_w[0]};
    rxcharisk = {d_k[2], d_k[1], d_k[0]};
    linkmask = d_mask;
    cnt_clr  = d_clr;
    model_edge();
    for (int k = 0; k < 3; k++) begin
      exp_ec[ECB*k +: ECB] = m_ec[k][ECB-1:0];
      exp_up[k]            = (m_st[k] == 2);
    end
    @(posedge clk);
    #1;
    check_eq("xdata",  xdata,  {e_xd[2], e_xd[1], e_xd[0]});
    check_eq("xcomma", xcomma, e_xc);
    check_eq("linkup", linkup, exp_up);
    check_eq("errcnt", errcnt, exp_ec);
    check_eq("err",    err,    e_err);
  endtask

  task automatic set_idle();
    for (int k = 0; k < 3; k++) begin d_w[k] = 16'h0000; d_k[k] = 2'b00; end
    d_clr = 1'b0; d_reset = 1'b0;
  endtask

  task automatic put(input int k, input logic [15:0] w, input logic [1:0] kk);
    d_w[k] = w; d_k[k] = kk;
  endtask

  task automatic rand_data(input int k);
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'h0000) w = 16'h0001;
    put(k, w, 2'b00);
  endtask

  task automatic rand_error(input int k);
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      0: put(k, 16'h0000, 2'b00);
      1: begin if (w == 16'h00BC) w = 16'h00BD; put(k, w, 2'b01); end
      2: put(k, w, 2'b10);
      default: put(k, w, 2'b11);
    endcase
  endtask

  initial begin
    set_idle();
    d_mask = 3'b000;

    // Reset values
    d_reset = 1'b1; step(); step();
    check_eq("rst_xdata", xdata, 48'h00BC00BC00BC);
    check_eq("rst_xcomma", xcomma, 3'b111);
    check_eq("rst_linkup", linkup, 3'b000);
    check_eq("rst_errcnt", errcnt, '0);
    check_eq("rst_err", err, 1'b0);
    d_reset = 1'b0;

    // Link 0 lock: comma + 15 data, first data passes on the 17th word
    put(0, 16'h00BC, 2'b01); step();
    for (int i = 0; i < 14; i++) begin put(0, 16'h0123, 2'b00); step(); end
    check_eq("lk0_not_up_15", linkup[0], 1'b0);
    step();
    check_eq("lk0_up_16", linkup[0], 1'b1);
    check_eq("lk0_16th_comma", xcomma[0], 1'b1);
    step();
    check_eq("lk0_first_data", xdata[15:0], 16'h0123);
    check_eq("lk0_first_xc", xcomma[0], 1'b0);

    // Single error while up
    put(0, 16'h0000, 2'b00); step();
    check_eq("err1_xdata", xdata[15:0], 16'h00BC);
    check_eq("err1_xc", xcomma[0], 1'b1);
    check_eq("err1_cnt", errcnt[ECB-1:0], 10'd1);
    check_eq("err1_pulse", err, 1'b1);
    check_eq("err1_up", linkup[0], 1'b1);
    put(0, 16'h4567, 2'b00); step();
    check_eq("err1_pulse_end", err, 1'b0);

    // Drain the bucket, then four back-to-back errors drop the link
    for (int i = 0; i < LEAK; i++) begin put(0, 16'h4567, 2'b00); step(); end
    for (int i = 0; i < 4; i++) begin
      put(0, 16'hBC00, 2'b10); step();
      check_eq("burst_up", linkup[0], (i < 3) ? 1'b1 : 1'b0);
    end
    check_eq("burst_cnt", errcnt[ECB-1:0], 10'd5);

    // Relock, then errors spaced by LEAK valid words never drop it
    put(0, 16'h00BC, 2'b01); step();
    for (int i = 0; i < 15; i++) begin put(0, 16'h1111, 2'b00); step(); end
    for (int j = 0; j < 8; j++) begin
      rand_error(0); step();
      for (int i = 0; i < LEAK; i++) begin rand_data(0); step(); end
      check_eq("leak_stays_up", linkup[0], 1'b1);
    end

    // Link 1: error at cnt = 10 in LOCK, relock needs a fresh comma
    put(1, 16'h00BC, 2'b01); step();
    for (int i = 0; i < 9; i++) begin put(1, 16'h2222, 2'b00); step(); end
    put(1, 16'hBC00, 2'b10); step();
    check_eq("lock_abort_cnt", errcnt[2*ECB-1:ECB], 10'd1);
    for (int i = 0; i < 15; i++) begin put(1, 16'h2222, 2'b00); step(); end
    check_eq("lock_abort_hunt", linkup[1], 1'b0);
    put(1, 16'h00BC, 2'b01); step();
    for (int i = 0; i < 15; i++) begin put(1, 16'h2222, 2'b00); step(); end
    check_eq("relock_up", linkup[1], 1'b1);

    // Link 2: saturate via comma/error pairs
    for (int i = 0; i < EC_MAX + 3; i++) begin
      put(2, 16'h00BC, 2'b01); step();
      put(2, 16'h0000, 2'b00); step();
    end
    check_eq("sat_cnt", errcnt[3*ECB-1:2*ECB], 10'h3FF);
    put(2, 16'h00BC, 2'b01); step();
    put(2, 16'h0000, 2'b00); d_clr = 1'b1; step();
    check_eq("clr_err_cnt", errcnt[3*ECB-1:2*ECB], 10'd1);
    put(2, 16'h0000, 2'b00); step();
    d_clr = 1'b0;
    check_eq("clr_cnt", errcnt[3*ECB-1:2*ECB], 10'd0);

    // All three up with distinct data, then mask link 1
    for (int k = 0; k < 3; k++) put(k, 16'h00BC, 2'b01);
    step();
    for (int i = 0; i < 16; i++) begin
      put(0, 16'h1111, 2'b00); put(1, 16'h2222, 2'b00); put(2, 16'h3333, 2'b00); step();
    end
    check_eq("all_up", linkup, 3'b111);
    check_eq("all_pass", xdata, 48'h333322221111);
    d_mask = 3'b010; step();
    check_eq("mask_xc", xcomma, 3'b010);
    check_eq("mask_xdata", xdata, 48'h333300BC1111);
    check_eq("mask_up", linkup[1], 1'b1);
    d_reset = 1'b1; step();
    check_eq("midrst_xdata", xdata, 48'h00BC00BC00BC);
    check_eq("midrst_xc", xcomma, 3'b111);
    check_eq("midrst_up", linkup, 3'b000);
    check_eq("midrst_ec", errcnt, '0);
    d_reset = 1'b0; d_mask = 3'b000;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 3; k++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 5) put(k, 16'h00BC, 2'b01);
        else if (r < 93) rand_data(k);
        else rand_error(k);
      end
      if ($urandom_range(0, 49) == 0) d_mask = 3'($urandom);
      d_clr   = ($urandom_range(0, 99) == 0);
      d_reset = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
